// File: rtl/mmio_bridge.sv
// Memory-mapped I/O bridge: single-port data RAM plus an I/O window of synchronised
// input channels with sticky rise capture, R/W output registers and a vsync frame counter.
module mmio_bridge #(
  parameter int ADDR_W  = 13,
  parameter int RAM_AW  = 12,
  parameter int DATA_W  = 32,
  parameter int NUM_IN  = 4,
  parameter int IN_W    = 8,
  parameter int NUM_OUT = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [ADDR_W-1:0]         address,
  input  logic [DATA_W-1:0]         data_in,
  input  logic                      wren,
  output logic [DATA_W-1:0]         data_out,
  input  logic [NUM_IN*IN_W-1:0]    in_ports,
  input  logic                      vsync,
  output logic [NUM_OUT*DATA_W-1:0] out_ports
);

  localparam int IN_BITS = NUM_IN * IN_W;

  logic              io_sel;
  logic [5:0]        off;
  logic [RAM_AW-1:0] ram_addr;
  logic              io_wr;
  logic              ram_we;
  logic              io_rd_side;

  assign io_sel     = address[ADDR_W-1];
  assign off        = address[5:0];
  assign ram_addr   = address[RAM_AW-1:0];
  assign io_wr      = io_sel & wren & ~reset;
  assign ram_we     = ~io_sel & wren & ~reset;
  assign io_rd_side = io_sel & ~wren & ~reset;

  // Two-flop synchronisers; the third flop only serves rising-edge detection.
  logic [IN_BITS-1:0] in_s1_reg, in_s2_reg, in_s3_reg;
  logic               vs_s1_reg, vs_s2_reg, vs_s3_reg;
  logic [IN_BITS-1:0] in_rise;
  logic               vs_rise;

  always_ff @(posedge clock) begin
    if (reset) begin
      in_s1_reg <= '0;
      in_s2_reg <= '0;
      in_s3_reg <= '0;
      vs_s1_reg <= 1'b0;
      vs_s2_reg <= 1'b0;
      vs_s3_reg <= 1'b0;
    end else begin
      in_s1_reg <= in_ports;
      in_s2_reg <= in_s1_reg;
      in_s3_reg <= in_s2_reg;
      vs_s1_reg <= vsync;
      vs_s2_reg <= vs_s1_reg;
      vs_s3_reg <= vs_s2_reg;
    end
  end

  assign in_rise = in_s2_reg & ~in_s3_reg;
  assign vs_rise = vs_s2_reg & ~vs_s3_reg;

  // Read-first single-port RAM; contents deliberately survive reset.
  logic [DATA_W-1:0] ram [2**RAM_AW];
  logic [DATA_W-1:0] ram_q_reg;

  always_ff @(posedge clock) begin
    if (ram_we) begin
      ram[ram_addr] <= data_in;
    end
    ram_q_reg <= ram[ram_addr];
  end

  // Sticky capture: clear-on-read is applied first so a coincident edge survives.
  logic [IN_BITS-1:0] sticky_reg, sticky_next;

  always_comb begin
    sticky_next = sticky_reg;
    for (int k = 0; k < NUM_IN; k++) begin
      if (io_rd_side && off == 6'(16 + k)) begin
        sticky_next[k*IN_W +: IN_W] = in_rise[k*IN_W +: IN_W];
      end else begin
        sticky_next[k*IN_W +: IN_W] = sticky_reg[k*IN_W +: IN_W] | in_rise[k*IN_W +: IN_W];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sticky_reg <= '0;
    end else begin
      sticky_reg <= sticky_next;
    end
  end

  logic [DATA_W-1:0] out_reg [NUM_OUT];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < NUM_OUT; k++) begin
        out_reg[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_OUT; k++) begin
        if (io_wr && off == 6'(32 + k)) begin
          out_reg[k] <= data_in;
        end
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_OUT; gi++) begin : g_out
      assign out_ports[gi*DATA_W +: DATA_W] = out_reg[gi];
    end
  endgenerate

  logic [DATA_W-1:0] frame_cnt_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      frame_cnt_reg <= '0;
    end else if (io_wr && off == 6'h3F) begin
      frame_cnt_reg <= '0;
    end else if (vs_rise) begin
      frame_cnt_reg <= frame_cnt_reg + 1'b1;
    end
  end

  logic [DATA_W-1:0] io_rd_next;

  always_comb begin
    io_rd_next = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (off == 6'(k)) begin
        io_rd_next[IN_W-1:0] = in_s2_reg[k*IN_W +: IN_W];
      end
      if (off == 6'(16 + k)) begin
        io_rd_next[IN_W-1:0] = sticky_reg[k*IN_W +: IN_W];
      end
    end
    for (int k = 0; k < NUM_OUT; k++) begin
      if (off == 6'(32 + k)) begin
        io_rd_next = out_reg[k];
      end
    end
    if (off == 6'h3F) begin
      io_rd_next = frame_cnt_reg;
    end
  end

  // zero_reg forces data_out to 0 after reset since the RAM output register is not reset.
  logic [DATA_W-1:0] io_rd_reg;
  logic              io_sel_reg;
  logic              zero_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      io_rd_reg  <= '0;
      io_sel_reg <= 1'b0;
      zero_reg   <= 1'b1;
    end else begin
      io_rd_reg  <= io_rd_next;
      io_sel_reg <= io_sel;
      zero_reg   <= 1'b0;
    end
  end

  assign data_out = zero_reg ? '0 : (io_sel_reg ? io_rd_reg : ram_q_reg);

endmodule

// File: tb/tb_mmio_bridge.sv
// Directed + randomized bench for mmio_bridge with a behavioural model of RAM, I/O registers,
// sticky captures and frame counting; an 8-bit build checks frame counter wrap.
module tb_mmio_bridge;

  logic          clock;
  logic          reset;
  logic [12:0]   address;
  logic [31:0]   data_in;
  logic          wren;
  logic [31:0]   data_out;
  logic [31:0]   in_ports;
  logic          vsync;
  logic [255:0]  out_ports;

  logic [12:0]   address8;
  logic [7:0]    data_in8;
  logic          wren8;
  logic [7:0]    data_out8;
  logic [7:0]    in_ports8;
  logic [7:0]    out_ports8;

  mmio_bridge dut (
    .clock(clock), .reset(reset), .address(address), .data_in(data_in), .wren(wren),
    .data_out(data_out), .in_ports(in_ports), .vsync(vsync), .out_ports(out_ports)
  );

  mmio_bridge #(.ADDR_W(13), .RAM_AW(12), .DATA_W(8), .NUM_IN(1), .IN_W(8), .NUM_OUT(1)) dut8 (
    .clock(clock), .reset(reset), .address(address8), .data_in(data_in8), .wren(wren8),
    .data_out(data_out8), .in_ports(in_ports8), .vsync(vsync), .out_ports(out_ports8)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  logic [31:0] ram_m [4096];
  logic [31:0] out_m [8];
  logic [7:0]  lvl_m [4];
  logic [7:0]  stk_m [4];
  int          frame_m;
  int          frame8_m;
  logic [11:0] addr_q [$];

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("[TB] %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic rd(input logic [12:0] a);
    address = a;
    wren = 1'b0;
    cyc();
  endtask

  task automatic wr(input logic [12:0] a, input logic [31:0] d);
    address = a;
    data_in = d;
    wren = 1'b1;
    cyc();
    wren = 1'b0;
  endtask

  // Apply a new input word and let it settle through sync and edge capture.
  task automatic set_in(input logic [31:0] v);
    for (int c = 0; c < 4; c++) begin
      stk_m[c] = stk_m[c] | (v[c*8 +: 8] & ~lvl_m[c]);
      lvl_m[c] = v[c*8 +: 8];
    end
    in_ports = v;
    address = 13'h0000;
    wren = 1'b0;
    repeat (4) cyc();
  endtask

  task automatic pulse();
    address = 13'h0000;
    wren = 1'b0;
    vsync = 1'b1;
    repeat (3) cyc();
    vsync = 1'b0;
    repeat (3) cyc();
    frame_m++;
    frame8_m = (frame8_m + 1) % 256;
  endtask

  initial begin
    logic [31:0] d;
    logic [31:0] old;
    logic [11:0] a;
    int ch;
    int n;

    reset = 1'b1;
    address = 13'h1023;
    data_in = 32'h0000_1234;
    wren = 1'b1;
    in_ports = '0;
    vsync = 1'b0;
    address8 = 13'h103F;
    data_in8 = '0;
    wren8 = 1'b0;
    in_ports8 = '0;
    for (int i = 0; i < 4096; i++) ram_m[i] = 'x;
    for (int k = 0; k < 8; k++) out_m[k] = '0;
    for (int c = 0; c < 4; c++) begin lvl_m[c] = '0; stk_m[c] = '0; end
    frame_m = 0;
    frame8_m = 0;

    repeat (3) cyc();
    chk("reset_data_out", data_out, 32'h0);
    chk("reset_out_ports_any", {31'b0, |out_ports}, 32'h0);
    reset = 1'b0;
    wren = 1'b0;
    rd(13'h1020); chk("rd_out0_after_reset", data_out, 32'h0);
    rd(13'h1FFF); chk("rd_frame_after_reset", data_out, 32'h0);
    chk("out3_after_reset_write", out_ports[3*32 +: 32], 32'h0);

    // RAM basics
    wr(13'h0005, 32'hDEAD_BEEF); ram_m[5] = 32'hDEAD_BEEF;
    rd(13'h0005); chk("ram_rd_5", data_out, 32'hDEAD_BEEF);
    rd(13'h1005); chk("io_unmapped_05", data_out, 32'h0);

    for (int i = 0; i < 16; i++) begin
      a = 12'($urandom_range(0, 4095));
      d = $urandom;
      wr({1'b0, a}, d);
      ram_m[a] = d;
      addr_q.push_back(a);
    end
    foreach (addr_q[i]) begin
      rd({1'b0, addr_q[i]});
      chk("ram_rand_rd", data_out, ram_m[addr_q[i]]);
    end

    // Same-cycle write returns the old RAM word
    old = ram_m[5];
    d = $urandom;
    wr(13'h0005, d);
    chk("ram_wr_rd_old", data_out, old);
    ram_m[5] = d;
    rd(13'h0005); chk("ram_rd_new", data_out, d);

    // Output registers
    for (int k = 0; k < 8; k++) begin
      d = $urandom;
      wr(13'(13'h1020 + k), d);
      out_m[k] = d;
    end
    for (int k = 0; k < 8; k++) begin
      chk("out_port_slice", out_ports[k*32 +: 32], out_m[k]);
      rd(13'(13'h1020 + k));
      chk("out_reg_rd", data_out, out_m[k]);
    end
    old = out_m[3];
    wr(13'h1023, 32'h0000_1234);
    chk("out_wr_rd_old", data_out, old);
    out_m[3] = 32'h0000_1234;
    chk("out3_1234", out_ports[3*32 +: 32], 32'h0000_1234);
    rd(13'h1028); chk("io_unmapped_28", data_out, 32'h0);
    wr(13'h1030, $urandom);
    rd(13'h1030); chk("io_unmapped_30", data_out, 32'h0);

    // Level and sticky: ch1 0x00 -> 0x81 -> 0x00
    set_in(32'h0);
    rd(13'h1011); chk("stk1_pre", data_out, 32'(stk_m[1])); stk_m[1] = '0;
    in_ports = 32'h0000_8100;
    address = 13'h0000;
    cyc(); cyc();
    rd(13'h1001); chk("lvl1_81", data_out, 32'h81);
    lvl_m[1] = 8'h81;
    stk_m[1] = 8'h81;
    set_in(32'h0);
    rd(13'h1011); chk("stk1_81", data_out, 32'h81); stk_m[1] = '0;
    rd(13'h1011); chk("stk1_cleared", data_out, 32'h0);

    for (int i = 0; i < 12; i++) begin
      set_in($urandom);
      ch = $urandom_range(0, 3);
      rd(13'(13'h1000 + ch)); chk("lvl_rand", data_out, 32'(lvl_m[ch]));
      ch = $urandom_range(0, 3);
      rd(13'(13'h1010 + ch)); chk("stk_rand", data_out, 32'(stk_m[ch]));
      stk_m[ch] = '0;
    end

    // A write cycle must not clear the sticky register
    set_in(32'h0);
    set_in(32'h00FF_0000);
    wr(13'h1012, $urandom);
    rd(13'h1012); chk("stk2_after_wr", data_out, 32'(stk_m[2])); stk_m[2] = '0;
    rd(13'h1012); chk("stk2_cleared", data_out, 32'h0);

    // Edge coincident with the clearing read
    set_in(32'h0);
    rd(13'h1010); chk("stk0_pre", data_out, 32'(stk_m[0])); stk_m[0] = '0;
    in_ports = 32'h0000_0001;
    lvl_m[0] = 8'h01;
    address = 13'h0000;
    cyc(); cyc();
    rd(13'h1010); chk("stk0_coincident", data_out, 32'h0);
    rd(13'h1010); chk("stk0_edge_kept", data_out, 32'h1);

    // Frame counter
    for (int i = 0; i < 5; i++) pulse();
    rd(13'h103F); chk("frame_5", data_out, 32'(frame_m));
    wr(13'h103F, $urandom); frame_m = 0;
    rd(13'h103F); chk("frame_cleared", data_out, 32'h0);
    n = $urandom_range(1, 9);
    for (int i = 0; i < n; i++) pulse();
    rd(13'h103F); chk("frame_rand", data_out, 32'(frame_m));
    while (frame8_m != 255) pulse();
    chk("frame8_255", {24'b0, data_out8}, 32'd255);
    pulse();
    chk("frame8_wrap", {24'b0, data_out8}, 32'(frame8_m));
    rd(13'h103F); chk("frame_after_wrap", data_out, 32'(frame_m));

    // Writes during reset are discarded; RAM survives reset
    d = $urandom;
    wr(13'h0007, d); ram_m[7] = d;
    set_in(32'h0);
    reset = 1'b1;
    address = 13'h0007; data_in = ~d; wren = 1'b1;
    cyc();
    address = 13'h1023; data_in = 32'h0000_1234; wren = 1'b1;
    cyc();
    reset = 1'b0;
    wren = 1'b0;
    for (int k = 0; k < 8; k++) out_m[k] = '0;
    for (int c = 0; c < 4; c++) stk_m[c] = '0;
    frame_m = 0;
    frame8_m = 0;
    chk("out3_reset_wr", out_ports[3*32 +: 32], 32'h0);
    rd(13'h0007); chk("ram_kept_reset", data_out, ram_m[7]);
    rd(13'h1023); chk("out3_rd_reset", data_out, 32'h0);
    rd(13'h103F); chk("frame_reset", data_out, 32'h0);
    chk("frame8_reset", {24'b0, data_out8}, 32'h0);
    wr(13'h1023, 32'h0000_1234);
    chk("out3_set", out_ports[3*32 +: 32], 32'h0000_1234);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
